// File: rtl/traffic_pkg.sv
// Shared types and default sizing for the traffic street model.
// Light codes match the controller's {l1,l0} output encoding.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        RED     = 2'b10,
        ILLEGAL = 2'b11
    } light_t;

    localparam int unsigned QW_DEF           = 4;
    localparam int unsigned DEPART_TICKS_DEF = 2;

endpackage

// File: rtl/lane_queue.sv
// One street lane: arrival edge detect, green-time departure timer and a
// saturating car counter with sticky overflow.
module lane_queue
    import traffic_pkg::*;
#(
    parameter int unsigned QW           = QW_DEF,
    parameter int unsigned DEPART_TICKS = DEPART_TICKS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          arr,
    input  light_t        light,
    output logic [QW-1:0] cnt,
    output logic          present,
    output logic          ovf
);

    localparam int unsigned   TW   = (DEPART_TICKS > 1) ? $clog2(DEPART_TICKS) : 1;
    localparam logic [QW-1:0] MAXQ = {QW{1'b1}};
    localparam logic [TW-1:0] LAST = TW'(DEPART_TICKS - 1);

    logic          arr_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [QW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          arrival, depart, window;

    always_comb begin
        arrival = arr & ~arr_q;
        window  = (light == GREEN) && (cnt_q != '0);
        depart  = 1'b0;
        timer_d = timer_q;
        // Any break in the green window restarts the departure count.
        if (!window) begin
            timer_d = '0;
        end else if (tick) begin
            if (timer_q == LAST) begin
                depart  = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (arrival && !depart) begin
            if (cnt_q == MAXQ) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (depart && !arrival) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arr_q   <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            arr_q   <= arr;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cnt     = cnt_q;
    assign present = (cnt_q != '0);
    assign ovf     = ovf_q;

endmodule

// File: rtl/traffic_sensor_model.sv
// Closed-loop street model for the two-street light controller: per-street
// car queues driving the sensors, plus a sticky unsafe-lights flag.
module traffic_sensor_model
    import traffic_pkg::*;
#(
    parameter int unsigned QW           = QW_DEF,
    parameter int unsigned DEPART_TICKS = DEPART_TICKS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic [1:0]    la,
    input  logic [1:0]    lb,
    output logic          sa,
    output logic          sb,
    output logic [QW-1:0] cnt_a,
    output logic [QW-1:0] cnt_b,
    output logic          ovf_a,
    output logic          ovf_b,
    output logic          conflict
);

    light_t light_a, light_b;
    logic   unsafe;
    logic   conflict_q;

    assign light_a = light_t'(la);
    assign light_b = light_t'(lb);

    lane_queue #(
        .QW           (QW),
        .DEPART_TICKS (DEPART_TICKS)
    ) u_lane_a (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .arr     (arr_a),
        .light   (light_a),
        .cnt     (cnt_a),
        .present (sa),
        .ovf     (ovf_a)
    );

    lane_queue #(
        .QW           (QW),
        .DEPART_TICKS (DEPART_TICKS)
    ) u_lane_b (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .arr     (arr_b),
        .light   (light_b),
        .cnt     (cnt_b),
        .present (sb),
        .ovf     (ovf_b)
    );

    // Safe only when at least one street is red and neither code is illegal.
    assign unsafe = ((light_a != RED) && (light_b != RED)) ||
                    (light_a == ILLEGAL) || (light_b == ILLEGAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_q <= 1'b0;
        end else if (unsafe) begin
            conflict_q <= 1'b1;
        end
    end

    assign conflict = conflict_q;

endmodule

// File: tb/tb_traffic_sensor_model.sv
// Directed scenarios plus random traffic, checked every cycle against a
// queue-arithmetic model of both streets.
module tb_traffic_sensor_model;

    localparam int unsigned QW   = 4;
    localparam int unsigned DT   = 2;
    localparam int          MAXQ = 15;

    logic          clk, reset, tick, arr_a, arr_b;
    logic [1:0]    la, lb;
    logic          sa, sb, ovf_a, ovf_b, conflict;
    logic [QW-1:0] cnt_a, cnt_b;

    traffic_sensor_model #(
        .QW           (QW),
        .DEPART_TICKS (DT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .la       (la),
        .lb       (lb),
        .sa       (sa),
        .sb       (sb),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .ovf_a    (ovf_a),
        .ovf_b    (ovf_b),
        .conflict (conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Street model: queue length changes by (arrival - departure), clamped at MAXQ.
    int m_cnt[2]   = '{0, 0};
    int m_prev[2]  = '{0, 0};
    int m_green[2] = '{0, 0};
    int m_ovf[2]   = '{0, 0};
    int m_conf     = 0;
    int v_arr[2], v_light[2], v_dep, v_new;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                m_cnt[l] = 0; m_prev[l] = 0; m_green[l] = 0; m_ovf[l] = 0;
            end
            m_conf = 0;
        end else begin
            v_arr[0] = int'(arr_a); v_arr[1] = int'(arr_b);
            v_light[0] = int'(la);  v_light[1] = int'(lb);
            if ((v_light[0] != 2 && v_light[1] != 2) || v_light[0] == 3 || v_light[1] == 3)
                m_conf = 1;
            for (int l = 0; l < 2; l++) begin
                v_dep = 0;
                if (v_light[l] == 0 && m_cnt[l] > 0) begin
                    if (tick) begin
                        m_green[l] = m_green[l] + 1;
                        if (m_green[l] == DT) begin
                            v_dep = 1;
                            m_green[l] = 0;
                        end
                    end
                end else begin
                    m_green[l] = 0;
                end
                v_new = m_cnt[l] + ((v_arr[l] == 1 && m_prev[l] == 0) ? 1 : 0) - v_dep;
                if (v_new > MAXQ) begin
                    v_new = MAXQ;
                    m_ovf[l] = 1;
                end
                m_cnt[l] = v_new;
                m_prev[l] = v_arr[l];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (checking && !reset) begin
            chk("cnt_a", int'(cnt_a), m_cnt[0]);
            chk("cnt_b", int'(cnt_b), m_cnt[1]);
            chk("sa", int'(sa), (m_cnt[0] != 0) ? 1 : 0);
            chk("sb", int'(sb), (m_cnt[1] != 0) ? 1 : 0);
            chk("ovf_a", int'(ovf_a), m_ovf[0]);
            chk("ovf_b", int'(ovf_b), m_ovf[1]);
            chk("conflict", int'(conflict), m_conf);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_a();
        arr_a = 1'b1; step(1); arr_a = 1'b0; step(1);
    endtask

    task automatic pulse_b();
        arr_b = 1'b1; step(1); arr_b = 1'b0; step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(1); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; arr_a = 1'b0; arr_b = 1'b0;
        la = 2'b10; lb = 2'b10;
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;
        checking = 1'b1;
        chk("reset cnt_a", int'(cnt_a), 0);
        chk("reset sb", int'(sb), 0);
        chk("reset conflict", int'(conflict), 0);

        // Three arrivals on A while red.
        repeat (3) pulse_a();
        chk("arrive cnt_a", int'(cnt_a), 3);
        chk("arrive sa", int'(sa), 1);
        chk("arrive cnt_b", int'(cnt_b), 0);

        // Drain A on green, one car per two ticks.
        la = 2'b00; tick = 1'b1;
        step(2); chk("drain cnt_a 2", int'(cnt_a), 2);
        step(2); chk("drain cnt_a 1", int'(cnt_a), 1);
        step(1); chk("drain cnt_a mid", int'(cnt_a), 1);
        step(1); chk("drain cnt_a 0", int'(cnt_a), 0);
        chk("drain sa", int'(sa), 0);
        la = 2'b10; tick = 1'b0;

        // Green on B interrupted by yellow restarts the timer.
        pulse_b(); pulse_b();
        lb = 2'b00; tick = 1'b1; step(1);
        lb = 2'b01; step(1);
        lb = 2'b00; step(1);
        chk("interrupt cnt_b", int'(cnt_b), 2);
        step(1);
        chk("resume cnt_b", int'(cnt_b), 1);
        step(2);
        lb = 2'b10; tick = 1'b0;

        // Saturation and sticky overflow on B.
        repeat (15) pulse_b();
        chk("sat cnt_b 15", int'(cnt_b), 15);
        chk("sat ovf_b pre", int'(ovf_b), 0);
        pulse_b();
        chk("sat cnt_b hold", int'(cnt_b), 15);
        chk("sat ovf_b", int'(ovf_b), 1);
        lb = 2'b00; tick = 1'b1; step(32);
        lb = 2'b10; tick = 1'b0;
        chk("drained cnt_b", int'(cnt_b), 0);
        chk("drained ovf_b", int'(ovf_b), 1);

        // Arrival coincides with a departure.
        pulse_a();
        la = 2'b00; tick = 1'b1; step(1);
        arr_a = 1'b1; step(1);
        chk("coincide cnt_a", int'(cnt_a), 1);
        chk("coincide sa", int'(sa), 1);
        arr_a = 1'b0; la = 2'b10; tick = 1'b0; step(1);
        chk("no conflict yet", int'(conflict), 0);

        // Unsafe combinations.
        la = 2'b00; lb = 2'b01; step(1);
        la = 2'b10; lb = 2'b10;
        chk("conflict both", int'(conflict), 1);
        step(3);
        chk("conflict sticky", int'(conflict), 1);
        do_reset();
        chk("conflict cleared", int'(conflict), 0);
        la = 2'b11; step(1); la = 2'b10;
        chk("conflict illegal", int'(conflict), 1);

        // Reset mid-drain clears outputs immediately.
        do_reset();
        repeat (3) pulse_a();
        la = 2'b00; tick = 1'b1; step(3);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk("rst cnt_a", int'(cnt_a), 0);
        chk("rst sa", int'(sa), 0);
        chk("rst ovf_b", int'(ovf_b), 0);
        chk("rst conflict", int'(conflict), 0);
        la = 2'b10; tick = 1'b0; arr_a = 1'b1;
        step(1); reset = 1'b0;
        step(1);
        chk("held through reset", int'(cnt_a), 1);
        step(3);
        chk("held no recount", int'(cnt_a), 1);
        arr_a = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            arr_a = ($urandom_range(0, 3) == 0);
            arr_b = ($urandom_range(0, 3) == 0);
            tick  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) la = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) lb = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            step(1);
            reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
